sal_rdwr_arbiter: RTL
=====================

Name: sal_rdwr_arbiter

Overview:
Arbitrates the AXI read-address (AR) and write-address (AW) channels onto the single request stream consumed by the bank address decoder. Write requests win over read requests when both arrive at the same time. Grants are batched per direction, up to MAX_BURST grants, to cut read/write turnarounds. An enforced idle gap is inserted on every direction switch. The output is a registered one-entry slot with a full valid/ready handshake.

Parameters:
ID_W, 4, AXI ID width
LEN_W, 8, AXI burst length width
ADDR_W, 32, AXI address width
MAX_BURST, 8, max consecutive grants in one direction while the other direction is pending (1..255)
TURN_GAP, 2, idle cycles inserted on a direction switch (0..15)
AGE_LIMIT, 64, starvation threshold in cycles (only with SAL_ARB_AGE_EN)

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
ar_valid  in  1  read address valid
ar_ready  out  1  read address accepted
ar_id  in  ID_W  read ID
ar_len  in  LEN_W  read burst length
ar_addr  in  ADDR_W  read address
aw_valid  in  1  write address valid
aw_ready  out  1  write address accepted
aw_id  in  ID_W  write ID
aw_len  in  LEN_W  write burst length
aw_addr  in  ADDR_W  write address
req_valid  out  1  request to decoder valid
req_ready  in  1  decoder accepted request
req_wr  out  1  1 = write, 0 = read
req_id  out  ID_W  granted ID
req_len  out  LEN_W  granted length
req_addr  out  ADDR_W  granted address
wr_mode  out  1  current direction, 1 = write (debug/perf)

Behaviour:
- Clock and reset: clk; rst_n synchronous, active-low.
- Reset values:
  - state = IDLE; req_valid = 0; req_wr/id/len/addr = 0; wr_mode = 0.
  - Grant counter, gap counter and age counter = 0.
  - ar_ready = aw_ready = 0.
- slot_free = !req_valid | req_ready.
- ar_ready = (state == RD) & slot_free. aw_ready = (state == WR) & slot_free. Both are combinational. Never both 1.
- Grant: ar_valid & ar_ready, or aw_valid & aw_ready.
  - On a grant the slot loads the channel fields next edge, with req_wr set to the channel direction and req_valid = 1.
  - With req_ready = 1 and no grant, req_valid clears next edge.
  - Slot contents are stable while req_valid & !req_ready.
- Latency: a granted input appears on req_* exactly 1 cycle after the grant edge. From IDLE, first grant happens 1 cycle after valid is seen (IDLE spends one cycle choosing a mode).
- IDLE:
  - aw_valid -> WR. Otherwise ar_valid -> RD. Tie goes to WR.
  - Grant counter cleared on entry to RD or WR.
- RD (wr_mode = 0):
  - Each grant increments the grant counter. It saturates at MAX_BURST.
  - Switch when aw_valid & (cnt == MAX_BURST | !ar_valid). Target WR via TURN, or directly to WR if TURN_GAP == 0.
  - Else if !ar_valid & !aw_valid -> IDLE.
  - Decisions use post-grant counts; the switch takes effect the cycle after the MAX_BURST-th grant.
- WR: symmetric to RD with the roles swapped; wr_mode = 1.
- TURN:
  - Gap counter loads TURN_GAP on entry and decrements each cycle; no grants during TURN.
  - When the counter reaches 1, the next state is the target direction.
  - If the target channel is no longer valid at that point, go to IDLE.
  - wr_mode shows the target direction during TURN.
- Output stall (req_ready = 0 with slot full): readies are 0, so no grants and counters hold. State transitions still evaluate.
- Reset asserted mid-burst or mid-TURN: all state returns to reset values next edge, and any pending slot is dropped.

Optional Feature:
SAL_ARB_AGE_EN:
- Defined: an age counter runs while the opposite-direction valid is pending in RD/WR and clears on any switch. When it reaches AGE_LIMIT, a switch is forced regardless of MAX_BURST. Counter width is clog2(AGE_LIMIT+1), saturating.
- Undefined: no age counter exists; switching depends only on MAX_BURST and channel emptiness.

Test Plan:
- Reset then idle, TURN_GAP = 2: all outputs 0, state IDLE. One AR (id=3, addr=0x100, len=0) -> ar_ready in cycle 1, req_valid/req_wr=0/req_id=3 in cycle 2.
- AR and AW asserted in the same IDLE cycle, both held valid, TURN_GAP = 2 -> AW is granted first.
- AR and AW continuously valid, MAX_BURST = 8, TURN_GAP = 2, req_ready = 1 -> pattern of 8 writes, 2 idle cycles, 8 reads, repeating; req_wr toggles every 10 cycles.
- In RD with AR queue of 3, aw_valid arrives after the 3rd grant -> switch via TURN (2 cycles) to WR before MAX_BURST is reached.
- req_ready held 0 for 5 cycles with slot full -> req_* stable, ar_ready = aw_ready = 0, grant counter unchanged.
- SAL_ARB_AGE_EN, AGE_LIMIT = 4, MAX_BURST = 255, both streams continuous -> direction switches after 4 cycles of the opposite side pending. Without the macro, 255 grants occur before a switch.

Source files
------------

// File: rtl/sal_rdwr_arbiter.sv
// sal_rdwr_arbiter: merges the AXI AR and AW address channels into one
// request stream for the bank address decoder.
//   - Writes win ties out of IDLE.
//   - Grants are batched per direction, up to MAX_BURST grants while the
//     other direction is waiting.
//   - TURN_GAP idle cycles are inserted on every direction switch.
//   - The output is a registered one-entry slot with a valid/ready handshake.
// Optional feature macro: SAL_ARB_AGE_EN. When defined, a switch is forced
// once the opposite direction has been pending for AGE_LIMIT cycles.
// Ports:
//   clk, rst_n                          clock, synchronous active-low reset
//   ar_valid/ar_ready/ar_id/ar_len/ar_addr   read address channel
//   aw_valid/aw_ready/aw_id/aw_len/aw_addr   write address channel
//   req_valid/req_ready/req_wr/req_id/req_len/req_addr   decoder request
//   wr_mode                             current (or TURN target) direction
module sal_rdwr_arbiter #(
  parameter int unsigned ID_W      = 4,
  parameter int unsigned LEN_W     = 8,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned MAX_BURST = 8,
  parameter int unsigned TURN_GAP  = 2,
  parameter int unsigned AGE_LIMIT = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ar_valid,
  output logic              ar_ready,
  input  logic [ID_W-1:0]   ar_id,
  input  logic [LEN_W-1:0]  ar_len,
  input  logic [ADDR_W-1:0] ar_addr,
  input  logic              aw_valid,
  output logic              aw_ready,
  input  logic [ID_W-1:0]   aw_id,
  input  logic [LEN_W-1:0]  aw_len,
  input  logic [ADDR_W-1:0] aw_addr,
  output logic              req_valid,
  input  logic              req_ready,
  output logic              req_wr,
  output logic [ID_W-1:0]   req_id,
  output logic [LEN_W-1:0]  req_len,
  output logic [ADDR_W-1:0] req_addr,
  output logic              wr_mode
);

  localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);
  localparam int unsigned GAP_W = 4;

  typedef enum logic [1:0] {ST_IDLE, ST_RD, ST_WR, ST_TURN} state_t;

  state_t             state_q, state_d;
  logic               wr_mode_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_inc;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic               slot_free, ar_grant, aw_grant;
  logic               switch_req, switch_to_wr;
  logic               age_force;

  // Handshake: a channel is ready only in its own mode with room in the slot.
  assign slot_free = !req_valid || req_ready;
  assign ar_ready  = (state_q == ST_RD) && slot_free;
  assign aw_ready  = (state_q == ST_WR) && slot_free;
  assign ar_grant  = ar_valid && ar_ready;
  assign aw_grant  = aw_valid && aw_ready;

  // Post-grant count, saturating at MAX_BURST.
  assign cnt_inc = ((ar_grant || aw_grant) && (cnt_q != CNT_W'(MAX_BURST)))
                   ? cnt_q + CNT_W'(1) : cnt_q;

`ifdef SAL_ARB_AGE_EN
  localparam int unsigned AGE_W = $clog2(AGE_LIMIT + 1);
  logic [AGE_W-1:0] age_q, age_d, age_inc;
  logic             opp_pending;

  // Age of the waiting opposite-direction request while a batch runs.
  assign opp_pending = ((state_q == ST_RD) && aw_valid) || ((state_q == ST_WR) && ar_valid);
  assign age_inc     = (opp_pending && (age_q != AGE_W'(AGE_LIMIT))) ? age_q + AGE_W'(1) : age_q;
  assign age_force   = (age_inc == AGE_W'(AGE_LIMIT));

  // Age survives only while the same batch continues; any switch clears it.
  always_comb begin
    age_d = '0;
    if ((state_d == state_q) && ((state_q == ST_RD) || (state_q == ST_WR)))
      age_d = age_inc;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) age_q <= '0;
    else        age_q <= age_d;
  end
`else
  assign age_force = 1'b0;
`endif

  // Next-state: mode selection, batch limits and turnaround gap.
  always_comb begin
    state_d      = state_q;
    wr_mode_d    = wr_mode;
    cnt_d        = cnt_q;
    gap_d        = gap_q;
    switch_req   = 1'b0;
    switch_to_wr = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (aw_valid) begin
          state_d   = ST_WR;
          wr_mode_d = 1'b1;
          cnt_d     = '0;
        end else if (ar_valid) begin
          state_d   = ST_RD;
          wr_mode_d = 1'b0;
          cnt_d     = '0;
        end
      end
      ST_RD: begin
        cnt_d = cnt_inc;
        if (aw_valid && ((cnt_inc == CNT_W'(MAX_BURST)) || !ar_valid || age_force)) begin
          switch_req   = 1'b1;
          switch_to_wr = 1'b1;
        end else if (!ar_valid && !aw_valid) begin
          state_d = ST_IDLE;
        end
      end
      ST_WR: begin
        cnt_d = cnt_inc;
        if (ar_valid && ((cnt_inc == CNT_W'(MAX_BURST)) || !aw_valid || age_force)) begin
          switch_req   = 1'b1;
          switch_to_wr = 1'b0;
        end else if (!ar_valid && !aw_valid) begin
          state_d = ST_IDLE;
        end
      end
      ST_TURN: begin
        // wr_mode already holds the target direction.
        if (gap_q <= GAP_W'(1)) begin
          cnt_d = '0;
          if (wr_mode ? aw_valid : ar_valid) state_d = wr_mode ? ST_WR : ST_RD;
          else                               state_d = ST_IDLE;
        end else begin
          gap_d = gap_q - GAP_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (switch_req) begin
      wr_mode_d = switch_to_wr;
      cnt_d     = '0;
      if (TURN_GAP == 0) begin
        state_d = switch_to_wr ? ST_WR : ST_RD;
      end else begin
        state_d = ST_TURN;
        gap_d   = GAP_W'(TURN_GAP);
      end
    end
  end

  // Control state registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      wr_mode <= 1'b0;
      cnt_q   <= '0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      wr_mode <= wr_mode_d;
      cnt_q   <= cnt_d;
      gap_q   <= gap_d;
    end
  end

  // Output slot: load on grant, drain on req_ready, hold while stalled.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      req_valid <= 1'b0;
      req_wr    <= 1'b0;
      req_id    <= '0;
      req_len   <= '0;
      req_addr  <= '0;
    end else if (aw_grant) begin
      req_valid <= 1'b1;
      req_wr    <= 1'b1;
      req_id    <= aw_id;
      req_len   <= aw_len;
      req_addr  <= aw_addr;
    end else if (ar_grant) begin
      req_valid <= 1'b1;
      req_wr    <= 1'b0;
      req_id    <= ar_id;
      req_len   <= ar_len;
      req_addr  <= ar_addr;
    end else if (req_ready) begin
      req_valid <= 1'b0;
    end
  end

endmodule
